divider_const_arb: RTL and testbench

- Shares one reciprocal-multiplier constant divider (quotient = (x * CONST_MULTI) >> BWI2) among four requesters.
- A round-robin arbiter feeds a 3-stage pipeline: operand capture, multiply, then quotient correction and remainder.
- A single result channel returns the result tagged with the requester id, under valid/ready backpressure.
- Sits between the pixel/sample producers and any consumer that needs exact x / DIVISOR with a remainder.

---
 rtl/divider_const_arb.sv | 115 +++++++++++
 tb/tb_divider_const_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_const_arb.sv
// divider_const_arb: four-way round-robin front end sharing one pipelined reciprocal-multiply constant divider.
module divider_const_arb #(
  parameter int BWI1 = 10,
  parameter int BWI2 = 14,
  parameter int BWO1 = 10,
  parameter logic [BWI2-1:0] CONST_MULTI = 14'b00010111010010,
  parameter int DIVISOR = 11,
  parameter int BWR = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req_valid,
  input  logic [4*BWI1-1:0] req_data,
  output logic [3:0]      req_ready,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [1:0]      res_id,
  output logic [BWO1-1:0] res_quot,
  output logic [BWR-1:0]  res_rem,
  output logic            res_fixed,
  output logic            busy
);
  localparam int PW = BWI1 + BWI2;
  localparam int QW = PW - BWI2;
  localparam int TW = PW + 2;
  logic [1:0] ptr_q, ptr_d, gid;
  logic [3:0] grant;
  logic en, xfer, ld;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic [BWI1-1:0] s1_x_q, s1_x_d, s2_x_q, s2_x_d;
  logic [PW-1:0] s2_prod_q, s2_prod_d;
  logic [QW-1:0] q_raw;
  logic signed [TW-1:0] t;
  logic neg, over;
  logic [BWO1-1:0] quot_c;
  logic [BWR-1:0] rem_c;
  logic res_valid_q, res_valid_d, res_fixed_q, res_fixed_d;
  logic [1:0] res_id_q, res_id_d;
  logic [BWO1-1:0] res_quot_q, res_quot_d;
  logic [BWR-1:0] res_rem_q, res_rem_d;
  // Descending scan so the requester closest to ptr wins.
  always_comb begin
    grant = '0;
    gid = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[ptr_q + 2'(k)]) begin
        gid = ptr_q + 2'(k);
        grant = 4'b1 << gid;
      end
    end
  end
  always_comb begin
    en = !res_valid_q | res_ready;
    req_ready = (en && !rst) ? grant : '0;
    xfer = |req_ready;
    ptr_d = xfer ? gid + 2'd1 : ptr_q;
    s1_v_d = en ? xfer : s1_v_q;
    s1_x_d = xfer ? req_data[gid*BWI1 +: BWI1] : s1_x_q;
    s1_id_d = xfer ? gid : s1_id_q;
    s2_v_d = en ? s1_v_q : s2_v_q;
    s2_x_d = en ? s1_x_q : s2_x_q;
    s2_id_d = en ? s1_id_q : s2_id_q;
    s2_prod_d = en ? PW'(s1_x_q) * PW'(CONST_MULTI) : s2_prod_q;
    q_raw = s2_prod_q[PW-1:BWI2];
    t = TW'(s2_x_q) - TW'(q_raw) * TW'(DIVISOR);
    neg = t[TW-1];
    over = !neg && (t >= TW'(DIVISOR));
    quot_c = BWO1'(neg ? q_raw - QW'(1) : over ? q_raw + QW'(1) : q_raw);
    rem_c = BWR'(neg ? t + TW'(DIVISOR) : over ? t - TW'(DIVISOR) : t);
    ld = en & s2_v_q;
    res_valid_d = en ? s2_v_q : res_valid_q;
    res_id_d = ld ? s2_id_q : res_id_q;
    res_quot_d = ld ? quot_c : res_quot_q;
    res_rem_d = ld ? rem_c : res_rem_q;
    res_fixed_d = ld ? (neg | over) : res_fixed_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      s1_v_q <= 1'b0;
      s1_id_q <= '0;
      s1_x_q <= '0;
      s2_v_q <= 1'b0;
      s2_id_q <= '0;
      s2_x_q <= '0;
      s2_prod_q <= '0;
      res_valid_q <= 1'b0;
      res_id_q <= '0;
      res_quot_q <= '0;
      res_rem_q <= '0;
      res_fixed_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      s1_v_q <= s1_v_d;
      s1_id_q <= s1_id_d;
      s1_x_q <= s1_x_d;
      s2_v_q <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_x_q <= s2_x_d;
      s2_prod_q <= s2_prod_d;
      res_valid_q <= res_valid_d;
      res_id_q <= res_id_d;
      res_quot_q <= res_quot_d;
      res_rem_q <= res_rem_d;
      res_fixed_q <= res_fixed_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_id = res_id_q;
  assign res_quot = res_quot_q;
  assign res_rem = res_rem_q;
  assign res_fixed = res_fixed_q;
  assign busy = s1_v_q | s2_v_q | res_valid_q;
endmodule

// File: tb/tb_divider_const_arb.sv
// tb_divider_const_arb: random and directed traffic checked against a queue-based reference model.
module tb_divider_const_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_valid, req_ready, req_ready2;
  logic [39:0] req_data;
  logic res_ready;
  logic res_valid, res_fixed, busy, res_valid2, res_fixed2, busy2;
  logic [1:0] res_id, res_id2;
  logic [9:0] res_quot, res_quot2;
  logic [3:0] res_rem, res_rem2;

  divider_const_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_quot(res_quot),
    .res_rem(res_rem), .res_fixed(res_fixed), .busy(busy));
  divider_const_arb #(.CONST_MULTI(14'd1489)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_id(res_id2), .res_quot(res_quot2),
    .res_rem(res_rem2), .res_fixed(res_fixed2), .busy(busy2));

  typedef struct {bit v; int id; int x;} slot_t;
  slot_t pipe[3];
  int src[4][$];
  int gseq[$];
  int gcnt[4];
  int total = 0, bad = 0, mptr = 0, delivered = 0;
  int last_id, last_q, last_r, last_f, last2_q, last2_r, last2_f;

  function automatic int rfix(int x, int cm);
    return ((x * cm) >> 14) != (x / 11) ? 1 : 0;
  endfunction

  function automatic bit pending();
    return src[0].size() > 0 || src[1].size() > 0 || src[2].size() > 0 || src[3].size() > 0 ||
           pipe[0].v || pipe[1].v || pipe[2].v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = src[i].size() > 0;
      req_data[i*10 +: 10] = src[i].size() > 0 ? 10'(src[i][0]) : 10'd0;
    end
  endtask

  task automatic step();
    bit men;
    int g;
    logic [3:0] er;
    @(negedge clk);
    men = !pipe[2].v || res_ready;
    g = -1;
    if (men)
      for (int k = 0; k < 4; k++)
        if (g < 0 && src[(mptr + k) % 4].size() > 0) g = (mptr + k) % 4;
    er = g < 0 ? 4'd0 : 4'(1 << g);
    chk("req_ready", req_ready, er);
    chk("req_ready_alt", req_ready2, er);
    chk("res_valid", res_valid, pipe[2].v);
    chk("res_valid_alt", res_valid2, pipe[2].v);
    chk("busy", busy, pipe[0].v | pipe[1].v | pipe[2].v);
    if (pipe[2].v) begin
      chk("res_id", res_id, pipe[2].id);
      chk("res_quot", res_quot, pipe[2].x / 11);
      chk("res_rem", res_rem, pipe[2].x % 11);
      chk("res_fixed", res_fixed, rfix(pipe[2].x, 1490));
      chk("res_quot_alt", res_quot2, pipe[2].x / 11);
      chk("res_rem_alt", res_rem2, pipe[2].x % 11);
      chk("res_fixed_alt", res_fixed2, rfix(pipe[2].x, 1489));
      if (res_ready) begin
        delivered++;
        last_id = int'(res_id); last_q = int'(res_quot); last_r = int'(res_rem); last_f = int'(res_fixed);
        last2_q = int'(res_quot2); last2_r = int'(res_rem2); last2_f = int'(res_fixed2);
      end
    end
    @(posedge clk);
    #1;
    if (men) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = g >= 0 ? '{1'b1, g, src[g][0]} : '{1'b0, 0, 0};
    end
    if (g >= 0) begin
      void'(src[g].pop_front());
      mptr = (g + 1) % 4;
      gcnt[g]++;
      gseq.push_back(g);
    end
    drive();
  endtask

  task automatic drain(input int maxc, input bit rnd);
    int n = 0;
    while (pending() && n < maxc) begin
      if (rnd) res_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    res_ready = 1'b1;
    total++;
    assert (n < maxc) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected_below=%0d", n, maxc);
    end
  endtask

  initial begin
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 0, 0};
    src[0].push_back(10); src[1].push_back(11); src[2].push_back(12); src[3].push_back(121);
    drive();
    #12;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_quot", res_quot, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // all four valid at once: grants 0..3 in order
    drain(50, 0);
    chk("t2_ngrants", gseq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_grant", gseq[i], i);
    chk("t2_last_id", last_id, 3);
    chk("t2_last_quot", last_q, 11);
    chk("t2_last_rem", last_r, 0);
    // single request on requester 2
    gseq.delete();
    src[2].push_back(1023);
    drive();
    drain(20, 0);
    chk("t1_ngrants", gseq.size(), 1);
    chk("t1_grant", gseq[0], 2);
    chk("t1_id", last_id, 2);
    chk("t1_quot", last_q, 93);
    chk("t1_rem", last_r, 0);
    chk("t1_fixed", last_f, 0);
    // backpressure mid-stream
    delivered = 0;
    for (int i = 0; i < 6; i++) src[$urandom_range(0, 3)].push_back(int'($urandom_range(0, 1023)));
    drive();
    for (int i = 0; i < 3; i++) step();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    res_ready = 1'b1;
    drain(50, 0);
    chk("t3_delivered", delivered, 6);
    // exhaustive sweep with random backpressure
    delivered = 0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    for (int x = 0; x < 1024; x++) src[x % 4].push_back(x);
    drive();
    drain(6000, 1);
    chk("t4_delivered", delivered, 1024);
    for (int i = 0; i < 4; i++) chk("t4_grant_count", gcnt[i], 256);
    // under-sized reciprocal on the alternate instance
    src[0].push_back(11);
    drive();
    drain(20, 0);
    chk("t5_quot11", last2_q, 1);
    chk("t5_rem11", last2_r, 0);
    chk("t5_fixed11", last2_f, 1);
    src[0].push_back(10);
    drive();
    drain(20, 0);
    chk("t5_quot10", last2_q, 0);
    chk("t5_rem10", last2_r, 10);
    chk("t5_fixed10", last2_f, 0);
    // reset with three operands in flight
    src[0].push_back(100); src[1].push_back(200); src[2].push_back(300);
    drive();
    for (int i = 0; i < 3; i++) step();
    src[0].push_back(7); src[3].push_back(8);
    drive();
    rst = 1'b1;
    #1;
    chk("t6_res_valid", res_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_id", res_id, 0);
    chk("t6_quot", res_quot, 0);
    chk("t6_rem", res_rem, 0);
    chk("t6_fixed", res_fixed, 0);
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 0, 0};
    mptr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_busy_after", busy, 0);
    gseq.delete();
    step();
    chk("t6_ngrants", gseq.size(), 1);
    chk("t6_first_grant", gseq.size() > 0 ? gseq[0] : -1, 0);
    drain(50, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
